// File: rtl/systolic_setup.sv
// Input skew stage feeding the systolic array: lane i of A/B operands and their
// valid/clear/last markers is delayed by i cycles behind a common output register.

module systolic_setup_lane #(
  parameter int W     = 19,
  parameter int DEPTH = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // stg_pipe[0] is the shared output register; the rest is the lane's skew.
  logic [DEPTH:0][W-1:0] stg_pipe;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_pipe <= '0;
    end else begin
      stg_pipe[0] <= d;
      for (int k = 1; k <= DEPTH; k++) stg_pipe[k] <= stg_pipe[k-1];
    end
  end

  assign q = stg_pipe[DEPTH];
endmodule

module systolic_setup #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ensys_i,
  input  logic                       bubble_i,
  input  logic                       batch_begin_i,
  input  logic                       batch_end_i,
  input  logic [SIZE*DATA_WIDTH-1:0] a_data_i,
  input  logic [SIZE*DATA_WIDTH-1:0] b_data_i,
  output logic [SIZE*DATA_WIDTH-1:0] a_o,
  output logic [SIZE*DATA_WIDTH-1:0] b_o,
  output logic [SIZE-1:0]            a_vld_o,
  output logic [SIZE-1:0]            b_vld_o,
  output logic [SIZE-1:0]            clr_o,
  output logic [SIZE-1:0]            last_o,
  output logic                       batch_done_o
);
  localparam int DW = DATA_WIDTH;
  localparam int LW = 2*DW + 3;  // {vld, clr, last, a, b}

  // Controls are captured at issue so they line up with the buffer read data.
  logic ensys_q, bubble_q, begin_q, end_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ensys_q  <= 1'b0;
      bubble_q <= 1'b0;
      begin_q  <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      ensys_q  <= ensys_i;
      bubble_q <= bubble_i;
      begin_q  <= batch_begin_i;
      end_q    <= batch_end_i;
    end
  end

  // Invalid and bubble slots carry zero operands, the MAC-neutral value.
  logic keep;
  assign keep = ensys_q & ~bubble_q;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [DW-1:0] a_in, b_in;
    logic [LW-1:0] d, q;

    assign a_in = keep ? a_data_i[i*DW +: DW] : '0;
    assign b_in = keep ? b_data_i[i*DW +: DW] : '0;
    assign d    = {ensys_q, ensys_q & begin_q, ensys_q & end_q, a_in, b_in};

    systolic_setup_lane #(.W(LW), .DEPTH(i)) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d      (d),
      .q      (q)
    );

    assign a_vld_o[i]        = q[LW-1];
    assign b_vld_o[i]        = q[LW-1];
    assign clr_o[i]          = q[LW-2];
    assign last_o[i]         = q[LW-3];
    assign a_o[i*DW +: DW]   = q[2*DW-1:DW];
    assign b_o[i*DW +: DW]   = q[DW-1:0];
  end

  assign batch_done_o = last_o[SIZE-1];
endmodule

// File: tb/tb_systolic_setup.sv
// Scoreboard bench for systolic_setup: an 8x8/8-bit instance and a 4-lane/16-bit
// instance share the control stream; expected lane outputs are queued at issue.

module tb_systolic_setup;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ensys = 1'b0, bubble = 1'b0, bbeg = 1'b0, bend = 1'b0;
  logic [63:0] a8_d = '0, b8_d = '0, a4_d = '0, b4_d = '0;
  logic [63:0] p8a = '0, p8b = '0, p4a = '0, p4b = '0;
  logic [63:0] a8, b8, a4, b4;
  logic [7:0]  av8, bv8, clr8, last8;
  logic [3:0]  av4, bv4, clr4, last4;
  logic        done8, done4;

  int cyc = 0, n_chk = 0, n_fail = 0;
  int n_done8 = 0, n_done4 = 0, n_clr8 = 0;
  bit fixed_pat = 1'b0;

  typedef struct {
    int          cyc;
    bit          s8;
    int          lane;
    bit          clr, last;
    logic [15:0] a, b;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_setup dut8 (
    .clk_i(clk), .rst_ni(rst_n), .ensys_i(ensys), .bubble_i(bubble),
    .batch_begin_i(bbeg), .batch_end_i(bend), .a_data_i(a8_d), .b_data_i(b8_d),
    .a_o(a8), .b_o(b8), .a_vld_o(av8), .b_vld_o(bv8), .clr_o(clr8),
    .last_o(last8), .batch_done_o(done8)
  );

  systolic_setup #(.DATA_WIDTH(16), .SIZE(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .ensys_i(ensys), .bubble_i(bubble),
    .batch_begin_i(bbeg), .batch_end_i(bend), .a_data_i(a4_d), .b_data_i(b4_d),
    .a_o(a4), .b_o(b4), .a_vld_o(av4), .b_vld_o(bv4), .clr_o(clr4),
    .last_o(last4), .batch_done_o(done4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] ea8, eb8, ea4, eb4;
    logic [7:0]  ev8, ec8, el8;
    logic [3:0]  ev4, ec4, el4;
    ea8 = '0; eb8 = '0; ea4 = '0; eb4 = '0;
    ev8 = '0; ec8 = '0; el8 = '0; ev4 = '0; ec4 = '0; el4 = '0;
    foreach (sbq[k]) begin
      if (sbq[k].cyc == cyc) begin
        if (sbq[k].s8) begin
          ea8[sbq[k].lane*8 +: 8] = sbq[k].a[7:0];
          eb8[sbq[k].lane*8 +: 8] = sbq[k].b[7:0];
          ev8[sbq[k].lane] = 1'b1;
          ec8[sbq[k].lane] = sbq[k].clr;
          el8[sbq[k].lane] = sbq[k].last;
        end else begin
          ea4[sbq[k].lane*16 +: 16] = sbq[k].a;
          eb4[sbq[k].lane*16 +: 16] = sbq[k].b;
          ev4[sbq[k].lane] = 1'b1;
          ec4[sbq[k].lane] = sbq[k].clr;
          el4[sbq[k].lane] = sbq[k].last;
        end
      end
    end
    for (int k = sbq.size() - 1; k >= 0; k--)
      if (sbq[k].cyc <= cyc) sbq.delete(k);

    chk("a_o8",    a8,           ea8);
    chk("b_o8",    b8,           eb8);
    chk("a_vld8",  64'(av8),     64'(ev8));
    chk("b_vld8",  64'(bv8),     64'(ev8));
    chk("clr8",    64'(clr8),    64'(ec8));
    chk("last8",   64'(last8),   64'(el8));
    chk("done8",   64'(done8),   64'(el8[7]));
    chk("a_o4",    a4,           ea4);
    chk("b_o4",    b4,           eb4);
    chk("a_vld4",  64'(av4),     64'(ev4));
    chk("b_vld4",  64'(bv4),     64'(ev4));
    chk("clr4",    64'(clr4),    64'(ec4));
    chk("last4",   64'(last4),   64'(el4));
    chk("done4",   64'(done4),   64'(el4[3]));
    if (done8)  n_done8++;
    if (done4)  n_done4++;
    if (|clr8)  n_clr8++;
  end

  // One issue cycle: controls now, read data for the previous issue now.
  task automatic drive(input bit ens, input bit bub, input bit beg, input bit fin);
    logic [63:0] n8a, n8b, n4a, n4b;
    exp_t e;
    @(posedge clk); #1;
    n8a = {$urandom, $urandom}; n8b = {$urandom, $urandom};
    n4a = {$urandom, $urandom}; n4b = {$urandom, $urandom};
    if (fixed_pat) begin
      for (int i = 0; i < 8; i++) begin
        n8a[i*8 +: 8] = 8'(i + 1);
        n8b[i*8 +: 8] = 8'(16 + i);
      end
      for (int i = 0; i < 4; i++) begin
        n4a[i*16 +: 16] = 16'(i + 1);
        n4b[i*16 +: 16] = 16'(16 + i);
      end
    end
    ensys = ens; bubble = bub; bbeg = beg; bend = fin;
    a8_d = p8a; b8_d = p8b; a4_d = p4a; b4_d = p4b;
    p8a = n8a; p8b = n8b; p4a = n4a; p4b = n4b;
    if (ens) begin
      for (int i = 0; i < 8; i++) begin
        e.cyc = cyc + 2 + i; e.s8 = 1'b1; e.lane = i; e.clr = beg; e.last = fin;
        e.a = bub ? 16'h0 : 16'(n8a[i*8 +: 8]);
        e.b = bub ? 16'h0 : 16'(n8b[i*8 +: 8]);
        sbq.push_back(e);
      end
      for (int i = 0; i < 4; i++) begin
        e.cyc = cyc + 2 + i; e.s8 = 1'b0; e.lane = i; e.clr = beg; e.last = fin;
        e.a = bub ? 16'h0 : n4a[i*16 +: 16];
        e.b = bub ? 16'h0 : n4b[i*16 +: 16];
        sbq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  task automatic run_batch(input int len, input int kv);
    for (int t = 0; t < len; t++) drive(1, t >= kv, t == 0, t == len - 1);
  endtask

  initial begin
    int d8, d4, c8;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    idle(20);

    fixed_pat = 1'b1;
    run_batch(8, 8);
    fixed_pat = 1'b0;
    idle(12);

    run_batch(8, 5);
    idle(12);

    d8 = n_done8; d4 = n_done4;
    run_batch(8, 8);
    run_batch(8, 6);
    idle(14);
    chk("done8_pulses", 64'(n_done8 - d8), 64'd2);
    chk("done4_pulses", 64'(n_done4 - d4), 64'd2);

    for (int t = 0; t < 6; t++) drive(1, 0, t == 0, 0);
    idle(1);
    #1 rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("rst_a8",  a8,  64'h0);
    chk("rst_b8",  b8,  64'h0);
    chk("rst_v8",  64'({av8, bv8, clr8, last8, done8}), 64'h0);
    chk("rst_a4",  a4,  64'h0);
    chk("rst_v4",  64'({av4, bv4, clr4, last4, done4}), 64'h0);
    idle(2);
    #1 rst_n = 1'b1;
    d8 = n_done8; d4 = n_done4; c8 = n_clr8;
    idle(20);
    chk("post_rst_done8", 64'(n_done8 - d8), 64'd0);
    chk("post_rst_done4", 64'(n_done4 - d4), 64'd0);
    chk("post_rst_clr8",  64'(n_clr8 - c8),  64'd0);

    run_batch(8, 8);
    idle(14);
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
